// File: rtl/mult_wallace_pipe.sv
// Three-stage pipelined Wallace-tree multiplier with valid/ready handshake and per-transaction signed mode.
// Optional accumulate mode (in_acc, out_p += product) is enabled by defining MULT_WALLACE_ACC_EN.
module mult_wallace_pipe #(
   parameter int unsigned A_W = 16,
   parameter int unsigned B_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [A_W-1:0]       in_a,
   input  logic [B_W-1:0]       in_b,
   input  logic                 in_signed,
`ifdef MULT_WALLACE_ACC_EN
   input  logic                 in_acc,
`endif
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [A_W+B_W-1:0]   out_p
);

   localparam int unsigned P_W = A_W + B_W;
   localparam int unsigned R0  = B_W + 1;

   // Rows remaining after lvl levels of 3:2 compression (each full group of 3 becomes 2).
   function automatic int unsigned rows_at(input int unsigned lvl);
      int unsigned n;
      n = R0;
      for (int unsigned k = 0; k < lvl; k++) n = n - n / 3;
      return n;
   endfunction

   function automatic int unsigned num_levels(input int unsigned rows);
      int unsigned n;
      int unsigned l;
      n = rows;
      l = 0;
      while (n > 2) begin
         n = n - n / 3;
         l++;
      end
      return l;
   endfunction

   localparam int unsigned LV = num_levels(R0);

   // Baugh-Wooley correction ones at bit positions A_W-1, B_W-1 and P_W-1 (zero-based).
   localparam logic [P_W-1:0] BW_K = (P_W'(1) << (A_W - 1)) + (P_W'(1) << (B_W - 1))
                                    + (P_W'(1) << (P_W - 1));

   logic                adv;
   logic [P_W-1:0]      pp_c   [B_W];
   logic [P_W-1:0]      red_c  [LV+1][R0];
   logic [P_W-1:0]      s1_pp  [B_W];
   logic                s1_valid;
   logic                s1_signed;
   logic [P_W-1:0]      s2_sum;
   logic [P_W-1:0]      s2_carry;
   logic                s2_valid;
   logic [P_W-1:0]      acc_base_c;
`ifdef MULT_WALLACE_ACC_EN
   logic                s1_acc;
   logic                s2_acc;
`endif

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Partial-product rows, already shifted into product columns; signed mode inverts the cross terms.
   always_comb begin
      for (int unsigned i = 0; i < B_W; i++) begin
         pp_c[i] = '0;
         for (int unsigned j = 0; j < A_W; j++) begin
            pp_c[i][i+j] = (in_a[j] & in_b[i])
                           ^ (in_signed & ((j == A_W - 1) != (i == B_W - 1)));
         end
      end
   end

   // Row-wise Wallace reduction of the registered matrix down to sum and carry rows.
   always_comb begin
      for (int unsigned l = 0; l <= LV; l++)
         for (int unsigned r = 0; r < R0; r++) red_c[l][r] = '0;
      for (int unsigned r = 0; r < B_W; r++) red_c[0][r] = s1_pp[r];
      red_c[0][B_W] = s1_signed ? BW_K : '0;
      for (int unsigned l = 0; l < LV; l++) begin
         for (int unsigned k = 0; k < R0 / 3; k++) begin
            if (k < rows_at(l) / 3) begin
               red_c[l+1][2*k]   = red_c[l][3*k] ^ red_c[l][3*k+1] ^ red_c[l][3*k+2];
               red_c[l+1][2*k+1] = ((red_c[l][3*k] & red_c[l][3*k+1])
                                   | (red_c[l][3*k] & red_c[l][3*k+2])
                                   | (red_c[l][3*k+1] & red_c[l][3*k+2])) << 1;
            end
         end
         for (int unsigned r = 0; r < R0; r++) begin
            if (r >= 3 * (rows_at(l) / 3) && r < rows_at(l))
               red_c[l+1][r - rows_at(l) / 3] = red_c[l][r];
         end
      end
   end

`ifdef MULT_WALLACE_ACC_EN
   assign acc_base_c = s2_acc ? out_p : '0;
`else
   assign acc_base_c = '0;
`endif

   // Pipeline registers; every stage holds while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < B_W; i++) s1_pp[i] <= '0;
         s1_valid  <= 1'b0;
         s1_signed <= 1'b0;
         s2_sum    <= '0;
         s2_carry  <= '0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_p     <= '0;
`ifdef MULT_WALLACE_ACC_EN
         s1_acc    <= 1'b0;
         s2_acc    <= 1'b0;
`endif
      end else if (adv) begin
         for (int unsigned i = 0; i < B_W; i++) s1_pp[i] <= pp_c[i];
         s1_valid  <= in_valid;
         s1_signed <= in_signed;
         s2_sum    <= red_c[LV][0];
         s2_carry  <= red_c[LV][1];
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) out_p <= s2_sum + s2_carry + acc_base_c;
`ifdef MULT_WALLACE_ACC_EN
         s1_acc    <= in_acc;
         s2_acc    <= s1_acc;
`endif
      end
   end

endmodule

// File: tb/tb_mult_wallace_pipe.sv
// Directed bench for mult_wallace_pipe: corners, streaming, backpressure, reset, 8x4 instance.
// Covers the accumulate build when MULT_WALLACE_ACC_EN is defined.
module tb_mult_wallace_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [15:0] in_a, in_b;
   logic [31:0] out_p;
`ifdef MULT_WALLACE_ACC_EN
   logic        in_acc;
`endif

   logic        s_in_valid, s_in_ready, s_in_signed, s_out_valid, s_out_ready;
   logic [7:0]  s_in_a;
   logic [3:0]  s_in_b;
   logic [11:0] s_out_p;

   int          tests;
   int          fails;
   int          popped;
   int          p0;
   logic [31:0] acc_model;
   logic [31:0] held;
   logic [31:0] expq [$];

   mult_wallace_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
`ifdef MULT_WALLACE_ACC_EN
      .in_acc(in_acc),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
   );

   mult_wallace_pipe #(.A_W(8), .B_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_a(s_in_a), .in_b(s_in_b), .in_signed(s_in_signed),
`ifdef MULT_WALLACE_ACC_EN
      .in_acc(1'b0),
`endif
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_p(s_out_p)
   );

   function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b, input logic sg);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      if (sg) begin
         sa = {{16{a[15]}}, a};
         sb = {{16{b[15]}}, b};
         return 32'(sa * sb);
      end
      return {16'h0, a} * {16'h0, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: score the output handshake, record accepted inputs, then advance.
   task automatic tick();
      logic        a_bit;
      logic [31:0] e;
`ifdef MULT_WALLACE_ACC_EN
      a_bit = in_acc;
`else
      a_bit = 1'b0;
`endif
      if (out_valid && out_ready) begin
         tests++;
         assert (expq.size() != 0) else begin
            fails++;
            $error("FAIL sb_spurious: observed product %h with no expected entry", out_p);
         end
         if (expq.size() != 0) begin
            check("sb_order", out_p, expq.pop_front());
            popped++;
         end
      end
      if (in_valid && in_ready) begin
         e = prod(in_a, in_b, in_signed) + (a_bit ? acc_model : 32'h0);
         acc_model = e;
         expq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b, input logic sg);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_signed = sg;
   endtask

   task automatic corner(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sg, input logic [31:0] exp);
      set_in(1'b1, a, b, sg);
      tick();
      in_valid = 1'b0;
      tick();
      check({tag, "_early"}, 32'(out_valid), 32'h0);
      tick();
      check({tag, "_vld"}, 32'(out_valid), 32'h1);
      check(tag, out_p, exp);
      tick();
   endtask

   task automatic drain(input string tag, input int base, input int n_exp);
      int t;
      t = 0;
      while (expq.size() != 0 && t < 20) begin
         tick();
         t++;
      end
      check({tag, "_cnt"}, 32'(popped - base), 32'(n_exp));
      check({tag, "_empty"}, 32'(expq.size()), 32'h0);
   endtask

   initial begin
      tests = 0; fails = 0; popped = 0; acc_model = 32'h0;
      rst_n = 1'b0; out_ready = 1'b1;
      set_in(1'b0, 16'h0, 16'h0, 1'b0);
`ifdef MULT_WALLACE_ACC_EN
      in_acc = 1'b0;
`endif
      s_in_valid = 1'b0; s_in_a = 8'h0; s_in_b = 4'h0; s_in_signed = 1'b0; s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_p", out_p, 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);
      check("rst_s_out_valid", 32'(s_out_valid), 32'h0);
      rst_n = 1'b1;
      tick();

      corner("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
      corner("u_0000_1234", 16'h0000, 16'h1234, 1'b0, 32'h00000000);
      corner("u_0001_abcd", 16'h0001, 16'hABCD, 1'b0, 32'h0000ABCD);
      corner("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
      corner("s_ffff_0002", 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE);
      corner("s_7fff_8000", 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000);

      // Back-to-back stream, alternating mode.
      p0 = popped;
      for (int i = 0; i < 100; i++) begin
         set_in(1'b1, 16'($urandom), 16'($urandom), 1'(i % 2));
         tick();
         if (i == 1) check("stream_first_early", 32'(out_valid), 32'h0);
         if (i >= 2) check("stream_vld", 32'(out_valid), 32'h1);
      end
      in_valid = 1'b0;
      drain("stream", p0, 100);

      // Fill pipeline, then stall the consumer for five cycles.
      p0 = popped;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 16'($urandom), 16'($urandom), 1'(i % 2));
         tick();
      end
      check("bp_full_vld", 32'(out_valid), 32'h1);
      out_ready = 1'b0;
      held = out_p;
      set_in(1'b1, 16'h1111, 16'h2222, 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_in_ready", 32'(in_ready), 32'h0);
         tick();
         check("bp_hold_p", out_p, held);
         check("bp_hold_vld", 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      drain("bp", p0, 3);

      // Reset with three transactions in flight.
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 16'($urandom), 16'($urandom), 1'(i % 2));
         tick();
      end
      rst_n = 1'b0;
      #1;
      check("rst_mid_vld", 32'(out_valid), 32'h0);
      check("rst_mid_p", out_p, 32'h0);
      expq.delete();
      acc_model = 32'h0;
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_mid_in_ready", 32'(in_ready), 32'h1);
      corner("post_rst", 16'h1234, 16'h0010, 1'b0, 32'h00012340);

      // 8x4 instance.
      s_in_valid = 1'b1; s_in_a = 8'hFF; s_in_b = 4'hF; s_in_signed = 1'b0;
      tick();
      s_in_a = 8'h80; s_in_b = 4'h8; s_in_signed = 1'b1;
      tick();
      s_in_valid = 1'b0;
      tick();
      check("s8x4_u_vld", 32'(s_out_valid), 32'h1);
      check("s8x4_u_ff_f", 32'(s_out_p), 32'h0EF1);
      tick();
      check("s8x4_s_vld", 32'(s_out_valid), 32'h1);
      check("s8x4_s_80_8", 32'(s_out_p), 32'h0400);
      tick();
      check("s8x4_idle", 32'(s_out_valid), 32'h0);

`ifdef MULT_WALLACE_ACC_EN
      in_acc = 1'b0;
      set_in(1'b1, 16'd3, 16'd4, 1'b0);
      tick();
      in_acc = 1'b1;
      set_in(1'b1, 16'd5, 16'd6, 1'b0);
      tick();
      in_valid = 1'b0;
      in_acc = 1'b0;
      tick();
      check("acc_first", out_p, 32'd12);
      tick();
      check("acc_second", out_p, 32'd42);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
